// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter sharing one UART transmitter: grants round-robin on ties,
// latches an NBYTES message and streams it MSB byte first over the Tx_WR/Tx_BUSY handshake.
module uart_tx_arbiter #(
    parameter int unsigned NBYTES  = 4,
    parameter int unsigned TIMEOUT = 16384,
    parameter int unsigned TO_W    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  req_a,
    input  logic [8*NBYTES-1:0]   data_a,
    input  logic [2:0]            baud_a,
    input  logic                  req_b,
    input  logic [8*NBYTES-1:0]   data_b,
    input  logic [2:0]            baud_b,
    input  logic                  tx_busy,
    output logic [7:0]            tx_data,
    output logic [2:0]            tx_baud_select,
    output logic                  tx_wr,
    output logic                  tx_en,
    output logic                  ack_a,
    output logic                  ack_b,
    output logic                  err_a,
    output logic                  err_b,
    output logic                  gnt_a,
    output logic                  gnt_b
);
    localparam int unsigned MSG_W = 8 * NBYTES;
    localparam int unsigned CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {IDLE, WR, WAIT, DONE, ERR} state_t;

    state_t             state, state_nxt;
    logic [MSG_W-1:0]   shift_reg, shift_nxt, shifted, sel_data;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic               owner_b, owner_nxt;
    logic               rr_last_b, rr_nxt;
    logic               pick_b;
    logic [7:0]         tx_data_nxt;
    logic [2:0]         baud_nxt;
    logic               tx_wr_nxt, tx_en_nxt;
    logic               ack_a_nxt, ack_b_nxt, err_a_nxt, err_b_nxt;
    logic               gnt_a_nxt, gnt_b_nxt;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_reg;
        byte_cnt_nxt = byte_cnt;
        to_cnt_nxt   = to_cnt;
        owner_nxt    = owner_b;
        rr_nxt       = rr_last_b;
        tx_data_nxt  = tx_data;
        baud_nxt     = tx_baud_select;
        tx_wr_nxt    = tx_wr;
        tx_en_nxt    = tx_en;
        gnt_a_nxt    = gnt_a;
        gnt_b_nxt    = gnt_b;
        ack_a_nxt    = 1'b0;
        ack_b_nxt    = 1'b0;
        err_a_nxt    = 1'b0;
        err_b_nxt    = 1'b0;

        // On a tie the requester not served last wins
        pick_b   = req_b && (!req_a || !rr_last_b);
        sel_data = pick_b ? data_b : data_a;
        shifted  = shift_reg << 8;

        case (state)
            IDLE: begin
                if (enable && (req_a || req_b)) begin
                    owner_nxt    = pick_b;
                    shift_nxt    = sel_data;
                    baud_nxt     = pick_b ? baud_b : baud_a;
                    byte_cnt_nxt = '0;
                    to_cnt_nxt   = '0;
                    gnt_a_nxt    = !pick_b;
                    gnt_b_nxt    = pick_b;
                    tx_en_nxt    = 1'b1;
                    tx_wr_nxt    = 1'b1;
                    tx_data_nxt  = sel_data[MSG_W-1 -: 8];
                    state_nxt    = WR;
                end
            end
            WR: begin
                if (tx_busy) begin
                    tx_wr_nxt = 1'b0;
                    state_nxt = WAIT;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    err_a_nxt = !owner_b;
                    err_b_nxt = owner_b;
                    gnt_a_nxt = 1'b0;
                    gnt_b_nxt = 1'b0;
                    tx_en_nxt = 1'b0;
                    tx_wr_nxt = 1'b0;
                    rr_nxt    = owner_b;
                    state_nxt = ERR;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                        ack_a_nxt = !owner_b;
                        ack_b_nxt = owner_b;
                        gnt_a_nxt = 1'b0;
                        gnt_b_nxt = 1'b0;
                        tx_en_nxt = 1'b0;
                        rr_nxt    = owner_b;
                        state_nxt = DONE;
                    end else begin
                        shift_nxt    = shifted;
                        byte_cnt_nxt = byte_cnt + CNT_W'(1);
                        to_cnt_nxt   = '0;
                        tx_wr_nxt    = 1'b1;
                        tx_data_nxt  = shifted[MSG_W-1 -: 8];
                        state_nxt    = WR;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; rr_last resets to B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            shift_reg      <= '0;
            byte_cnt       <= '0;
            to_cnt         <= '0;
            owner_b        <= 1'b0;
            rr_last_b      <= 1'b1;
            tx_data        <= 8'h00;
            tx_baud_select <= 3'b000;
            tx_wr          <= 1'b0;
            tx_en          <= 1'b0;
            ack_a          <= 1'b0;
            ack_b          <= 1'b0;
            err_a          <= 1'b0;
            err_b          <= 1'b0;
            gnt_a          <= 1'b0;
            gnt_b          <= 1'b0;
        end else begin
            state          <= state_nxt;
            shift_reg      <= shift_nxt;
            byte_cnt       <= byte_cnt_nxt;
            to_cnt         <= to_cnt_nxt;
            owner_b        <= owner_nxt;
            rr_last_b      <= rr_nxt;
            tx_data        <= tx_data_nxt;
            tx_baud_select <= baud_nxt;
            tx_wr          <= tx_wr_nxt;
            tx_en          <= tx_en_nxt;
            ack_a          <= ack_a_nxt;
            ack_b          <= ack_b_nxt;
            err_a          <= err_a_nxt;
            err_b          <= err_b_nxt;
            gnt_a          <= gnt_a_nxt;
            gnt_b          <= gnt_b_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter model
// (shortened busy hold so the run stays small).
module tb_uart_tx_arbiter;
    localparam int unsigned NBYTES  = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned TO_W    = 15;
    localparam int          HOLD    = 40;
    localparam int          LIMIT   = 3000;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, tx_busy;
    logic [31:0] data_a = '0, data_b = '0;
    logic [2:0]  baud_a = '0, baud_b = '0;
    logic [7:0]  tx_data;
    logic [2:0]  tx_baud_select;
    logic        tx_wr, tx_en, ack_a, ack_b, err_a, err_b, gnt_a, gnt_b;

    int          n_tests = 0, n_fail = 0;
    logic [10:0] exp_byte_q[$];
    int          exp_evt_q[$];
    bit          stuck = 1'b0;

    uart_tx_arbiter #(.NBYTES(NBYTES), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_a(req_a), .data_a(data_a), .baud_a(baud_a),
        .req_b(req_b), .data_b(data_b), .baud_b(baud_b),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_baud_select(tx_baud_select),
        .tx_wr(tx_wr), .tx_en(tx_en), .ack_a(ack_a), .ack_b(ack_b),
        .err_a(err_a), .err_b(err_b), .gnt_a(gnt_a), .gnt_b(gnt_b)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: busy rises a few cycles after seeing tx_wr, then holds HOLD cycles
    int dly = 0, hold = 0;
    logic busy_r = 1'b0;
    assign tx_busy = busy_r;
    always @(posedge clk) begin
        if (!reset || stuck) begin
            busy_r <= 1'b0; dly <= 0; hold <= 0;
        end else if (hold != 0) begin
            hold <= hold - 1;
            if (hold == 1) busy_r <= 1'b0;
        end else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) begin busy_r <= 1'b1; hold <= HOLD; end
        end else if (tx_wr && !busy_r) begin
            dly <= 3;
        end
    end

    // Output monitor: pops expected bytes on each tx_wr rise and expected ack/err events
    logic        tx_wr_q = 1'b0;
    int          wr_run = 0;
    logic [10:0] e;
    logic [3:0]  code;
    always @(negedge clk) begin
        if (tx_wr && !tx_wr_q) begin
            check("gnt_onehot", 32'(gnt_a & gnt_b), 32'(0));
            if (exp_byte_q.size() == 0) check("unexpected_wr", 32'(tx_data), 32'hFFFF_FFFF);
            else begin
                e = exp_byte_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e[7:0]));
                check("tx_baud", 32'(tx_baud_select), 32'(e[10:8]));
            end
        end
        if (tx_wr) wr_run++;
        else begin
            if (tx_wr_q && stuck) check("wr_len", 32'(wr_run), 32'(TIMEOUT));
            wr_run = 0;
        end
        tx_wr_q = tx_wr;
        code = {err_b, err_a, ack_b, ack_a};
        if (code != 4'h0) begin
            if (exp_evt_q.size() == 0) check("unexpected_evt", 32'(code), 32'(0));
            else check("evt", 32'(code), 32'(exp_evt_q.pop_front()));
            check("gnt_drop", 32'({gnt_a, gnt_b, tx_en}), 32'(0));
        end
    end

    task automatic push_msg(input bit is_b, input logic [31:0] d, input logic [2:0] baud);
        for (int i = 0; i < int'(NBYTES); i++) exp_byte_q.push_back({baud, d[31-8*i -: 8]});
        exp_evt_q.push_back(is_b ? 2 : 1);
    endtask

    task automatic wait_evt(input logic [3:0] mask);
        int n = 0;
        while (n < LIMIT && (({err_b, err_a, ack_b, ack_a} & mask) == 4'h0)) begin
            @(negedge clk); n++;
        end
        if (n >= LIMIT) check("wait_evt_budget", 32'(mask), 32'(0));
    endtask

    task automatic wait_wr(input logic lvl);
        int n = 0;
        while (n < LIMIT && tx_wr !== lvl) begin @(negedge clk); n++; end
        if (n >= LIMIT) check("wait_wr_budget", 32'(lvl), 32'(~lvl));
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_outs", 32'({tx_data, tx_baud_select, tx_wr, tx_en, ack_a, ack_b,
                               err_a, err_b, gnt_a, gnt_b}), 32'(0));
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_gnt", 32'({gnt_a, gnt_b}), 32'(0));

        // enable=0 blocks a grant; then B is served
        enable = 1'b0; data_b = 32'h0F1E_2D3C; baud_b = 3'b011; req_b = 1'b1;
        repeat (5) @(negedge clk);
        check("en_block", 32'(gnt_b), 32'(0));
        push_msg(1'b1, data_b, baud_b);
        enable = 1'b1;
        wait_evt(4'b0010); req_b = 1'b0;

        // Single message with grant latency
        data_a = 32'hA888_5501; baud_a = 3'b111;
        push_msg(1'b0, data_a, baud_a);
        @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        check("gnt_latency", 32'({gnt_a, tx_wr, tx_en}), 32'(3'b111));
        wait_evt(4'b0001); req_a = 1'b0;

        // Mid-frame data/req changes are ignored
        @(negedge clk);
        data_a = 32'hA888_5501; baud_a = 3'b010;
        push_msg(1'b0, data_a, baud_a);
        req_a = 1'b1;
        wait_wr(1'b1); wait_wr(1'b0);
        data_a = 32'hFFFF_FFFF; baud_a = 3'b101; req_a = 1'b0;
        wait_evt(4'b0001);

        // Timeout with busy stuck low, then B served normally
        @(negedge clk);
        stuck = 1'b1; data_a = 32'hC3C3_0000; baud_a = 3'b100;
        exp_byte_q.push_back({baud_a, 8'hC3});
        exp_evt_q.push_back(4);
        req_a = 1'b1;
        wait_evt(4'b0100); req_a = 1'b0;
        @(negedge clk);
        check("err_once", 32'({err_a, tx_wr}), 32'(0));
        stuck = 1'b0;
        data_b = 32'h1234_5678; baud_b = 3'b001;
        push_msg(1'b1, data_b, baud_b);
        req_b = 1'b1;
        wait_evt(4'b0010); req_b = 1'b0;

        // Round-robin with both requests held: A, B, A
        @(negedge clk);
        data_a = 32'h1122_3344; baud_a = 3'b101;
        data_b = 32'h5566_7788; baud_b = 3'b110;
        push_msg(1'b0, data_a, baud_a);
        push_msg(1'b1, data_b, baud_b);
        push_msg(1'b0, 32'h99AA_BBCC, 3'b101);
        req_a = 1'b1; req_b = 1'b1;
        wait_evt(4'b0001);
        data_a = 32'h99AA_BBCC;
        wait_evt(4'b0010); req_b = 1'b0;
        wait_evt(4'b0001); req_a = 1'b0;

        // Reset during the second byte's WAIT aborts without ack
        @(negedge clk);
        data_a = 32'hCAFE_BABE; baud_a = 3'b100;
        push_msg(1'b0, data_a, baud_a);
        req_a = 1'b1;
        wait_wr(1'b1); wait_wr(1'b0); wait_wr(1'b1); wait_wr(1'b0);
        reset = 1'b0;
        exp_byte_q.delete(); exp_evt_q.delete();
        @(negedge clk);
        check("rst_mid", 32'({tx_wr, tx_en, gnt_a, gnt_b, ack_a}), 32'(0));
        push_msg(1'b0, data_a, baud_a);
        reset = 1'b1;
        wait_evt(4'b0001); req_a = 1'b0;

        repeat (4) @(negedge clk);
        check("byte_q_empty", 32'(exp_byte_q.size()), 32'(0));
        check("evt_q_empty", 32'(exp_evt_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
